// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Bundle of the MEM-stage, loader and dmem buses around dmem_arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_func3;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [2:0]  dbg_func3;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_func3,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_func3,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_wdata, mem_func3, mem_wr_en, mem_rd_en,
        input  mem_rdata
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_func3,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_func3,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_wdata, mem_func3, mem_wr_en, mem_rd_en,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares dmem between the MEM stage (default priority) and an
//            aged loader port that stalls the CPU for at most one cycle.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int AGE_LIMIT = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(AGE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_AGE_MAX = CNT_W'(AGE_LIMIT);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic             r_dbg_rvalid;
    logic [31:0]      r_dbg_rdata;

    logic             w_dbg_win;
    logic             w_cpu_act;

    // Loader wins in ARB when the CPU is idle or the loader has aged out;
    // reset suppresses it so a pending loader write is dropped.
    assign w_dbg_win = !rst && (r_state == ST_ARB) && bus.dbg_req &&
                       (!bus.cpu_req || (r_wait_cnt == c_AGE_MAX));
    assign w_cpu_act = !rst && !w_dbg_win && bus.cpu_req;

    assign bus.mem_addr   = w_dbg_win ? bus.dbg_addr  : bus.cpu_addr;
    assign bus.mem_wdata  = w_dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
    assign bus.mem_func3  = w_dbg_win ? bus.dbg_func3 : bus.cpu_func3;
    assign bus.mem_wr_en  = (w_dbg_win && bus.dbg_we)  || (w_cpu_act && bus.cpu_we);
    assign bus.mem_rd_en  = (w_dbg_win && !bus.dbg_we) || (w_cpu_act && !bus.cpu_we);

    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.cpu_stall  = w_dbg_win && bus.cpu_req;
    assign bus.dbg_gnt    = w_dbg_win;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.dbg_rdata  = r_dbg_rdata;

    always_comb begin
        w_state_nxt = ST_ARB;
        w_wait_nxt  = r_wait_cnt;
        if ((r_state == ST_ARB) && w_dbg_win && bus.cpu_req) begin
            w_state_nxt = ST_GUARD;
        end
        if (w_dbg_win || !bus.dbg_req) begin
            w_wait_nxt = '0;
        end else if (r_wait_cnt != c_AGE_MAX) begin
            w_wait_nxt = r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ARB;
            r_wait_cnt   <= '0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_dbg_rvalid <= w_dbg_win && !bus.dbg_we;
            if (w_dbg_win && !bus.dbg_we) begin
                r_dbg_rdata <= bus.mem_rdata;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a loader read scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_q[$];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.AGE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every read-valid pulse must match the oldest expected load.
    always @(negedge clk) begin
        if (bus.dbg_rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_rvalid: got rdata=%h, required no rvalid", bus.dbg_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.dbg_rdata !== e) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h, required %h", bus.dbg_rdata, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic go_idle();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.dbg_req = 0; bus.dbg_we = 0;
        step(); step();
    endtask

    task automatic test_reset();
        rst = 1;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h4; bus.cpu_wdata = 32'h1;
        bus.cpu_func3 = 3'd2;
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h8; bus.dbg_wdata = 32'h2;
        bus.dbg_func3 = 3'd2; bus.mem_rdata = 32'h0;
        step(); settle();
        checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b, required 0", bus.dbg_gnt); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b, required 0", bus.mem_wr_en); end
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b, required 0", bus.mem_rd_en); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b, required 0", bus.cpu_stall); end
        checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b, required 0", bus.dbg_rvalid); end
        checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h, required 0", bus.dbg_rdata); end
        bus.cpu_req = 0; bus.dbg_req = 0;
        step();
        rst = 0;
        step();
    endtask

    task automatic test_cpu_access();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10; bus.cpu_func3 = 3'd2;
        bus.mem_rdata = 32'h12345678;
        settle();
        checks++; if (bus.mem_rd_en !== 1'b1) begin errors++; $display("FAIL cpu_ld_rd_en: got %b, required 1", bus.mem_rd_en); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL cpu_ld_wr_en: got %b, required 0", bus.mem_wr_en); end
        checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL cpu_ld_addr: got %h, required 00000010", bus.mem_addr); end
        checks++; if (bus.cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL cpu_ld_rdata: got %h, required 12345678", bus.cpu_rdata); end
        checks++; if ({bus.cpu_stall, bus.dbg_gnt} !== 2'b00) begin errors++; $display("FAIL cpu_ld_stall_gnt: got %b, required 00", {bus.cpu_stall, bus.dbg_gnt}); end
        step();
        bus.cpu_we = 1; bus.cpu_addr = 32'h24; bus.cpu_wdata = 32'hA5A5_0F0F; bus.cpu_func3 = 3'd1;
        settle();
        checks++; if ({bus.mem_wr_en, bus.mem_rd_en} !== 2'b10) begin errors++; $display("FAIL cpu_st_en: got %b, required 10", {bus.mem_wr_en, bus.mem_rd_en}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_func3} !== {32'h24, 32'hA5A5_0F0F, 3'd1}) begin
            errors++; $display("FAIL cpu_st_bus: got %h/%h/%0d, required 00000024/a5a50f0f/1", bus.mem_addr, bus.mem_wdata, bus.mem_func3); end
        go_idle();
    endtask

    task automatic test_dbg_store_idle();
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h40; bus.dbg_wdata = 32'hDEADBEEF;
        bus.dbg_func3 = 3'd2; bus.cpu_addr = 32'h0;
        settle();
        checks++; if (bus.dbg_gnt !== 1'b1) begin errors++; $display("FAIL dst_gnt: got %b, required 1", bus.dbg_gnt); end
        checks++; if ({bus.mem_wr_en, bus.mem_rd_en} !== 2'b10) begin errors++; $display("FAIL dst_en: got %b, required 10", {bus.mem_wr_en, bus.mem_rd_en}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h40, 32'hDEADBEEF}) begin
            errors++; $display("FAIL dst_bus: got %h/%h, required 00000040/deadbeef", bus.mem_addr, bus.mem_wdata); end
        step();
        bus.dbg_req = 0;
        settle();
        checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL dst_rvalid: got %b, required 0", bus.dbg_rvalid); end
        go_idle();
    endtask

    task automatic test_contention();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h80; bus.dbg_func3 = 3'd2;
        bus.mem_rdata = 32'h1111_2222;
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++; if ({bus.dbg_gnt, bus.cpu_stall} !== 2'b00 || bus.mem_addr !== 32'h10) begin
                errors++; $display("FAIL cont_wait c%0d: gnt/stall=%b addr=%h, required 00 00000010", c, {bus.dbg_gnt, bus.cpu_stall}, bus.mem_addr); end
            step();
        end
        bus.mem_rdata = 32'hCAFE_F00D;
        settle();
        checks++; if ({bus.dbg_gnt, bus.cpu_stall} !== 2'b11) begin errors++; $display("FAIL cont_grant: gnt/stall=%b, required 11", {bus.dbg_gnt, bus.cpu_stall}); end
        checks++; if (bus.mem_addr !== 32'h80 || bus.mem_rd_en !== 1'b1) begin
            errors++; $display("FAIL cont_grant_bus: addr=%h rd=%b, required 00000080 1", bus.mem_addr, bus.mem_rd_en); end
        if (bus.dbg_gnt === 1'b1) exp_q.push_back(32'hCAFE_F00D);
        step();
        bus.dbg_addr = 32'h84; bus.mem_rdata = 32'h3333_4444;
        settle();
        checks++; if (bus.dbg_rvalid !== 1'b1) begin errors++; $display("FAIL cont_rvalid: got %b, required 1", bus.dbg_rvalid); end
        checks++; if ({bus.dbg_gnt, bus.cpu_stall} !== 2'b00 || bus.mem_addr !== 32'h10) begin
            errors++; $display("FAIL cont_guard: gnt/stall=%b addr=%h, required 00 00000010", {bus.dbg_gnt, bus.cpu_stall}, bus.mem_addr); end
        step();
        bus.cpu_req = 0; bus.mem_rdata = 32'h5555_6666;
        settle();
        checks++; if ({bus.dbg_gnt, bus.dbg_rvalid} !== 2'b10) begin errors++; $display("FAIL cont_back_arb: gnt/rvalid=%b, required 10", {bus.dbg_gnt, bus.dbg_rvalid}); end
        if (bus.dbg_gnt === 1'b1) exp_q.push_back(32'h5555_6666);
        step();
        bus.dbg_req = 0;
        go_idle();
    endtask

    task automatic test_withdraw();
        bus.cpu_req = 1; bus.cpu_we = 0;
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h90; bus.dbg_wdata = 32'h77;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL wd_pre c%0d: gnt=%b, required 0", c, bus.dbg_gnt); end
            step();
        end
        bus.dbg_req = 0;
        step();
        bus.dbg_req = 1;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++; if (bus.dbg_gnt !== (c == 4)) begin errors++; $display("FAIL wd_rewait c%0d: gnt=%b, required %b", c, bus.dbg_gnt, c == 4); end
            step();
        end
        bus.dbg_req = 0;
        go_idle();
    endtask

    task automatic test_reset_mid();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'hA0; bus.dbg_wdata = 32'h99;
        repeat (4) step();
        rst = 1;
        settle();
        checks++; if ({bus.dbg_gnt, bus.mem_wr_en, bus.cpu_stall} !== 3'b000) begin
            errors++; $display("FAIL rmid_forced: gnt/wr/stall=%b, required 000", {bus.dbg_gnt, bus.mem_wr_en, bus.cpu_stall}); end
        step();
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++; if (bus.dbg_gnt !== (c == 4) || bus.dbg_rvalid !== 1'b0) begin
                errors++; $display("FAIL rmid_after c%0d: gnt=%b rvalid=%b, required %b 0", c, bus.dbg_gnt, bus.dbg_rvalid, c == 4); end
            step();
        end
        checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h, required 0", bus.dbg_rdata); end
        bus.dbg_req = 0;
        go_idle();
    endtask

    task automatic test_guard_idle();
        bus.cpu_req = 1; bus.cpu_we = 0;
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'hB0; bus.dbg_wdata = 32'h42;
        repeat (4) step();
        settle();
        checks++; if ({bus.dbg_gnt, bus.cpu_stall} !== 2'b11) begin errors++; $display("FAIL gi_grant: gnt/stall=%b, required 11", {bus.dbg_gnt, bus.cpu_stall}); end
        step();
        bus.cpu_req = 0;
        settle();
        checks++; if ({bus.dbg_gnt, bus.mem_wr_en, bus.mem_rd_en} !== 3'b000) begin
            errors++; $display("FAIL gi_guard: gnt/wr/rd=%b, required 000", {bus.dbg_gnt, bus.mem_wr_en, bus.mem_rd_en}); end
        step();
        settle();
        checks++; if ({bus.dbg_gnt, bus.mem_wr_en} !== 2'b11) begin errors++; $display("FAIL gi_after: gnt/wr=%b, required 11", {bus.dbg_gnt, bus.mem_wr_en}); end
        step();
        bus.dbg_req = 0;
        go_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [3];
        data[0] = 32'h0BAD_CAFE; data[1] = 32'h1357_9BDF; data[2] = 32'hFEDC_BA98;
        bus.cpu_req = 0; bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_func3 = 3'd4;
        for (int c = 0; c < 3; c++) begin
            bus.dbg_addr = 32'h100 + 32'(c * 4);
            bus.mem_rdata = data[c];
            settle();
            checks++; if (bus.dbg_gnt !== 1'b1 || bus.mem_addr !== 32'h100 + 32'(c * 4) || bus.mem_func3 !== 3'd4) begin
                errors++; $display("FAIL b2b c%0d: gnt=%b addr=%h f3=%0d, required 1 %h 4", c, bus.dbg_gnt, bus.mem_addr, bus.mem_func3, 32'h100 + 32'(c * 4)); end
            if (bus.dbg_gnt === 1'b1) exp_q.push_back(data[c]);
            step();
        end
        bus.dbg_req = 0;
        go_idle();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_func3 = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0; bus.dbg_func3 = 0;
        bus.mem_rdata = 0;
        #1;
        test_reset();
        test_cpu_access();
        test_dbg_store_idle();
        test_contention();
        test_withdraw();
        test_reset_mid();
        test_guard_idle();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d loads left without rvalid, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory (`dmem`) between the pipeline MEM stage and a debug/loader port. The pipeline has default priority. The loader is guaranteed service after a bounded wait, and while it holds the memory the MEM stage is stalled. The block sits between the MEM stage and `dmem`, so `dmem` no longer connects to the MEM stage directly. `cpu_stall` feeds the hazard unit.

## Interface
Parameters:
- AGE_LIMIT, 4: number of consecutive denied cycles the loader tolerates before it is forced through. Legal values are ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- cpu_req  in  1  MEM-stage access request (memRead | memWrite).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address (aluOut).
- cpu_wdata  in  32  store data (rs2 value).
- cpu_func3  in  3  access size/sign (instr[14:12]).
- cpu_rdata  out  32  load data, combinational from mem_rdata.
- cpu_stall  out  1  MEM stage must hold this cycle.
- dbg_req  in  1  loader request; held until dbg_gnt.
- dbg_we  in  1  loader store/load select.
- dbg_addr  in  32  loader address.
- dbg_wdata  in  32  loader store data.
- dbg_func3  in  3  loader access size.
- dbg_gnt  out  1  loader access performed this cycle.
- dbg_rvalid  out  1  one-cycle pulse: dbg_rdata is valid.
- dbg_rdata  out  32  registered loader read data.
- mem_addr  out  32  to dmem.address.
- mem_wdata  out  32  to dmem.data_in.
- mem_func3  out  3  to dmem.func3.
- mem_wr_en  out  1  to dmem.wr_en.
- mem_rd_en  out  1  to dmem.rd_en.
- mem_rdata  in  32  from dmem.data_out; combinational read.

## Operation
- State register has two states:
  - ARB: normal arbitration.
  - GUARD: the CPU has absolute priority for one cycle.
- wait_cnt is $clog2(AGE_LIMIT+1) bits wide and saturates at AGE_LIMIT.
- Winner selection is combinational each cycle:
  - **dbg wins** when state = ARB and dbg_req = 1 and (cpu_req = 0 or wait_cnt = AGE_LIMIT).
  - **cpu wins** otherwise, whenever cpu_req = 1.
  - **Idle** when neither request is present. Both enables are 0; mem_addr/wdata/func3 follow the cpu inputs.
- When dbg wins:
  - mem_* outputs are driven from the dbg_* inputs; mem_wr_en = dbg_we, mem_rd_en = !dbg_we.
  - dbg_gnt = 1 and cpu_stall = cpu_req.
- When cpu wins:
  - mem_* outputs are driven from the cpu_* inputs; mem_wr_en = cpu_we, mem_rd_en = !cpu_we.
  - dbg_gnt = 0 and cpu_stall = 0.
- cpu_rdata = mem_rdata at all times. It is only meaningful when the CPU wins.
- wait_cnt update at the clock edge:
  - Cleared to 0 if dbg_gnt = 1 or dbg_req = 0.
  - Otherwise incremented, saturating at AGE_LIMIT.
- State transitions:
  - ARB → GUARD when dbg_gnt and cpu_req are both 1.
  - GUARD → ARB unconditionally after one cycle.
  - In GUARD with cpu_req = 0, the loader is still denied. The loader therefore always sees at least one dead cycle after a stall-causing grant.
- On a dbg load grant, dbg_rdata ← mem_rdata at the edge, and dbg_rvalid = 1 in the next cycle only. dbg_rvalid is never asserted for store grants.
- A stalled CPU request keeps its inputs stable. The pipeline inserts a bubble into MEM/WB (regWrite = 0) during cpu_stall; that is the hazard unit's responsibility, not this block's.

## Timing
- Reset values: state = ARB, wait_cnt = 0, dbg_rvalid = 0, dbg_rdata = 0.
- While rst = 1, combinational outputs are forced: dbg_gnt = 0, cpu_stall = 0, mem_wr_en = 0, mem_rd_en = 0.
- An access the loader would have won in a reset cycle is dropped and no write occurs.
- CPU latency is 0 cycles. Load data returns in the same cycle, unchanged from the unshared path.
- Loader latency:
  - dbg_gnt arrives in the request cycle if the CPU is idle (and state = ARB).
  - Under continuous CPU traffic, dbg_gnt arrives at most AGE_LIMIT cycles after dbg_req rises, +1 if it rises in GUARD.
  - Read data follows 1 cycle after the grant.
- Maximum CPU stall is 1 cycle per loader access. Two stall cycles are never consecutive.
- dbg_req dropped before grant is legal. The counter clears and no access occurs.

## Test plan
1. **CPU-only load.** cpu_req = 1, cpu_we = 0, cpu_addr = 0x10, mem_rdata = 0x12345678. Expect mem_rd_en = 1, mem_addr = 0x10, cpu_rdata = 0x12345678, cpu_stall = 0, dbg_gnt = 0.
2. **Loader store with idle CPU.** dbg_req = 1, dbg_we = 1, dbg_addr = 0x40, dbg_wdata = 0xDEADBEEF. Expect dbg_gnt = 1 and mem_wr_en = 1 in the same cycle, and dbg_rvalid stays 0.
3. **Contention, AGE_LIMIT = 4.** cpu_req held high and a dbg load from 0x80 raised at cycle 0. Expect:
   - Cycles 0–3: cpu wins, with wait_cnt reaching 4.
   - Cycle 4: dbg_gnt = 1, cpu_stall = 1, mem_addr = 0x80.
   - Cycle 5: dbg_rvalid = 1 with the captured data; GUARD, so a new dbg_req is denied and the CPU is served.
   - Cycle 6: back to ARB.
4. **Withdrawn request.** dbg_req raised for 2 cycles under CPU traffic, then dropped. Expect wait_cnt = 0 afterwards. A new dbg_req then waits the full 4 cycles.
5. **Reset mid-contention.** rst = 1 in the cycle the loader store would win (wait_cnt = 4). Expect mem_wr_en = 0 and dbg_gnt = 0. After rst falls, expect wait_cnt = 0, state = ARB, and dbg_rvalid = 0.
6. **Idle CPU in GUARD.** After a stall-causing grant, drop cpu_req with dbg_req held. Expect dbg_gnt = 0 in the GUARD cycle and dbg_gnt = 1 in the following cycle.
